fight_round_scheduler: RTL
==========================

Name: fight_round_scheduler

Overview:
- Match-level controller for the two-player fighting game; sits above the per-player datapaths and the seven-segment health display.
- Arbitrates action requests from both players into a single serialised commit stream and waits for the datapath to resolve each commit.
- Watches both health values, scores rounds and declares the match winner after WIN_ROUNDS round wins.

Parameters:
- HW, 2, health width in bits (matches display path).
- WIN_ROUNDS, 2, round wins needed to take the match (1..7).
- TIMEOUT, 15, resolve-timeout in clk cycles (used only with feature macro).

Ports:
- clk  in  1  system clock.
- resetGame  in  1  asynchronous active-low reset.
- req1  in  1  player-1 action request, held until ack1.
- action1  in  3  player-1 action code, stable while req1 high.
- req2  in  1  player-2 action request, held until ack2.
- action2  in  3  player-2 action code.
- ack1, ack2  out  1  one-cycle grant/acknowledge pulse.
- commit  out  1  one-cycle pulse to datapath: apply commit_action for commit_player.
- commit_player  out  1  0 = player 1, 1 = player 2; held until next commit.
- commit_action  out  3  granted action code; held until next commit.
- resolve_done  in  1  datapath pulse: commit applied, health valid.
- health1, health2  in  HW  current health from datapaths.
- round_reset  out  1  one-cycle pulse: datapaths reload full health and start states.
- rounds1, rounds2  out  3  round wins per player.
- firstWin, secondWin  out  1  match winner flags, sticky until reset.
- isGameOver  out  1  high in MATCH_OVER.

Behaviour:
- Reset (async, resetGame=0): state=ROUND_INIT, all pulses 0, commit_player=0, commit_action=0, rounds1=rounds2=0, firstWin=secondWin=isGameOver=0, prio=0 (player 1 preferred).
- ROUND_INIT: round_reset=1 for exactly one cycle -> ARM.
- ARM: one settle cycle (health reload) -> FIGHT.
- FIGHT: if no req, stay. If exactly one req, grant it. If both, grant player indicated by prio. Grant cycle: ackN=1, commit=1, commit_player/commit_action latched same edge; prio := other player after every grant (round-robin). -> RESOLVE.
- Requests are ignored (no ack) in all states other than FIGHT; a req held across a round boundary is served in the next FIGHT.
- RESOLVE: wait for resolve_done -> CHECK. resolve_done outside RESOLVE is ignored.
- CHECK (1 cycle, samples health):
  - both nonzero -> FIGHT.
  - health2==0, health1!=0 -> rounds1+1 -> ROUND_END.
  - health1==0, health2!=0 -> rounds2+1 -> ROUND_END.
  - both zero -> draw, no score -> ROUND_END.
- ROUND_END: if rounds1==WIN_ROUNDS, firstWin=1 -> MATCH_OVER; else if rounds2==WIN_ROUNDS, secondWin=1 -> MATCH_OVER; else -> ROUND_INIT.
- MATCH_OVER: isGameOver=1; absorbing until resetGame low. No acks, no commits, no round_reset.
- Round counters saturate at WIN_ROUNDS; never wrap.
- Latency: req high in FIGHT -> ack/commit on next rising edge; resolve_done -> next FIGHT grant possible 2 cycles later.
- Reset mid-RESOLVE: abandon commit, outputs to reset values; no ack reissued.

Optional Feature:
- RESOLVE_TIMEOUT_EN defined: counter (width to hold TIMEOUT) runs in RESOLVE; if TIMEOUT cycles elapse without resolve_done, go to CHECK anyway (health sampled as-is); counter clears on entry to RESOLVE.
- Not defined: RESOLVE waits indefinitely; no counter logic.

Decomposition:
- Shared package: state enum (ROUND_INIT, ARM, FIGHT, RESOLVE, CHECK, ROUND_END, MATCH_OVER), action-code constants (3-bit), player-select constants P1=0/P2=1, default HW.
- One sub-module natural: fight_rr_arbiter (2-requester round-robin with prio flag, grant one-hot, update on grant enable).

Test Plan:
- Reset then idle -> one round_reset pulse in cycle 1, state FIGHT by cycle 3, all flags 0.
- req1 with action1=3'b010 alone -> ack1 and commit same cycle, commit_player=0, commit_action=010; no further grant until resolve_done.
- req1 and req2 together for three grants -> grant order P1, P2, P1 (prio alternates).
- Datapath drives health2=0 on resolve_done, WIN_ROUNDS=2, repeated twice -> rounds1 goes 1 then 2, firstWin=1, isGameOver=1, later reqs get no ack.
- health1=health2=0 in CHECK -> rounds unchanged, new round_reset pulse.
- With RESOLVE_TIMEOUT_EN, TIMEOUT=15, commit with no resolve_done -> CHECK entered after 15 cycles; resetGame low mid-RESOLVE -> immediate reset values.

Source files
------------

// File: rtl/fight_round_scheduler_pkg.sv
// rtl/fight_round_scheduler_pkg.sv - shared states, action codes and helpers for the match scheduler
package fight_round_scheduler_pkg;

    typedef enum logic [2:0] {
        ROUND_INIT,
        ARM,
        FIGHT,
        RESOLVE,
        CHECK,
        ROUND_END,
        MATCH_OVER
    } state_t;

    localparam logic [2:0] ACT_IDLE    = 3'd0;
    localparam logic [2:0] ACT_PUNCH   = 3'd1;
    localparam logic [2:0] ACT_KICK    = 3'd2;
    localparam logic [2:0] ACT_BLOCK   = 3'd3;
    localparam logic [2:0] ACT_SPECIAL = 3'd4;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int DEFAULT_HW = 2;

    // Round counters stop at the match threshold instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] limit);
        return (value >= limit) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/fight_rr_arbiter.sv
// rtl/fight_rr_arbiter.sv - two-requester round-robin arbiter, priority flips after every grant
module fight_rr_arbiter
    import fight_round_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = (prio == P2) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= P1;
        end else if (en && (grant != 2'b00)) begin
            prio <= grant[0] ? P2 : P1;
        end
    end

endmodule

// File: rtl/fight_round_scheduler.sv
// rtl/fight_round_scheduler.sv - match controller: serialises commits, scores rounds; RESOLVE_TIMEOUT_EN adds resolve timeout
module fight_round_scheduler
    import fight_round_scheduler_pkg::*;
#(
    parameter int HW         = DEFAULT_HW,
    parameter int WIN_ROUNDS = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          resetGame,
    input  logic          req1,
    input  logic [2:0]    action1,
    input  logic          req2,
    input  logic [2:0]    action2,
    output logic          ack1,
    output logic          ack2,
    output logic          commit,
    output logic          commit_player,
    output logic [2:0]    commit_action,
    input  logic          resolve_done,
    input  logic [HW-1:0] health1,
    input  logic [HW-1:0] health2,
    output logic          round_reset,
    output logic [2:0]    rounds1,
    output logic [2:0]    rounds2,
    output logic          firstWin,
    output logic          secondWin,
    output logic          isGameOver
);

    localparam logic [2:0] WIN3 = 3'(WIN_ROUNDS);

    state_t     state, state_n;
    logic       ack1_n, ack2_n, commit_n, round_reset_n;
    logic       commit_player_n;
    logic [2:0] commit_action_n;
    logic [2:0] rounds1_n, rounds2_n;
    logic       first_win_n, second_win_n;
    logic       grant_en;
    logic [1:0] grant;
    logic       resolve_exit;
    logic       h1_zero, h2_zero;

    fight_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (resetGame),
        .req   ({req2, req1}),
        .en    (grant_en),
        .grant (grant)
    );

`ifdef RESOLVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Zero outside RESOLVE, so every entry into RESOLVE starts a fresh count.
    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            tmo_cnt <= '0;
        end else if (state != RESOLVE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign resolve_exit = resolve_done || (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign resolve_exit = resolve_done;
`endif

    assign h1_zero    = (health1 == '0);
    assign h2_zero    = (health2 == '0);
    assign isGameOver = (state == MATCH_OVER);

    always_comb begin
        state_n         = state;
        ack1_n          = 1'b0;
        ack2_n          = 1'b0;
        commit_n        = 1'b0;
        round_reset_n   = 1'b0;
        commit_player_n = commit_player;
        commit_action_n = commit_action;
        rounds1_n       = rounds1;
        rounds2_n       = rounds2;
        first_win_n     = firstWin;
        second_win_n    = secondWin;
        grant_en        = 1'b0;

        case (state)
            ROUND_INIT: begin
                round_reset_n = 1'b1;
                state_n       = ARM;
            end
            ARM: begin
                state_n = FIGHT;
            end
            FIGHT: begin
                grant_en = 1'b1;
                if (grant[0]) begin
                    ack1_n          = 1'b1;
                    commit_n        = 1'b1;
                    commit_player_n = P1;
                    commit_action_n = action1;
                    state_n         = RESOLVE;
                end else if (grant[1]) begin
                    ack2_n          = 1'b1;
                    commit_n        = 1'b1;
                    commit_player_n = P2;
                    commit_action_n = action2;
                    state_n         = RESOLVE;
                end
            end
            RESOLVE: begin
                if (resolve_exit) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (!h1_zero && !h2_zero) begin
                    state_n = FIGHT;
                end else begin
                    // A double knock-out is a draw and scores nobody.
                    state_n = ROUND_END;
                    if (h2_zero && !h1_zero) begin
                        rounds1_n = sat_inc(rounds1, WIN3);
                    end else if (h1_zero && !h2_zero) begin
                        rounds2_n = sat_inc(rounds2, WIN3);
                    end
                end
            end
            ROUND_END: begin
                if (rounds1 == WIN3) begin
                    first_win_n = 1'b1;
                    state_n     = MATCH_OVER;
                end else if (rounds2 == WIN3) begin
                    second_win_n = 1'b1;
                    state_n      = MATCH_OVER;
                end else begin
                    state_n = ROUND_INIT;
                end
            end
            MATCH_OVER: begin
                state_n = MATCH_OVER;
            end
            default: begin
                state_n = ROUND_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            state         <= ROUND_INIT;
            ack1          <= 1'b0;
            ack2          <= 1'b0;
            commit        <= 1'b0;
            round_reset   <= 1'b0;
            commit_player <= P1;
            commit_action <= ACT_IDLE;
            rounds1       <= 3'd0;
            rounds2       <= 3'd0;
            firstWin      <= 1'b0;
            secondWin     <= 1'b0;
        end else begin
            state         <= state_n;
            ack1          <= ack1_n;
            ack2          <= ack2_n;
            commit        <= commit_n;
            round_reset   <= round_reset_n;
            commit_player <= commit_player_n;
            commit_action <= commit_action_n;
            rounds1       <= rounds1_n;
            rounds2       <= rounds2_n;
            firstWin      <= first_win_n;
            secondWin     <= second_win_n;
        end
    end

endmodule
